// File: rtl/mux_sweep_sequencer_pkg.sv
// Shared types and sizes for the mux/decoder sweep sequencer.
package mux_seq_pkg;

  localparam int NUM_VECTORS = 32;
  localparam int IDX_W       = 5;
  localparam int SEL_W       = 3;
  localparam int DEC_W       = 2;
  localparam int CNT_W       = 4;
  localparam int ERR_W       = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_sweep_sequencer_if.sv
// Control, datapath-drive and result signals of the sweep sequencer.
// Compare ports exist only when MUX_SEQ_COMPARE_EN is defined.
interface mux_seq_if;
  import mux_seq_pkg::*;

  logic                   start;
  logic                   abort;
  logic [SEL_W-1:0]       sel;
  logic [DEC_W-1:0]       dec_in;
  logic                   mux_out;
  logic                   busy;
  logic                   done;
  logic                   table_valid;
  logic [NUM_VECTORS-1:0] truth_table;
`ifdef MUX_SEQ_COMPARE_EN
  logic [NUM_VECTORS-1:0] expected;
  logic                   mismatch;
  logic [ERR_W-1:0]       err_count;
`endif

  // Controller/datapath side: requests sweeps, returns the mux output.
  modport master (
    output start, abort, mux_out,
`ifdef MUX_SEQ_COMPARE_EN
    output expected,
    input  mismatch, err_count,
`endif
    input  sel, dec_in, busy, done, table_valid, truth_table
  );

  // Sequencer side.
  modport slave (
    input  start, abort, mux_out,
`ifdef MUX_SEQ_COMPARE_EN
    input  expected,
    output mismatch, err_count,
`endif
    output sel, dec_in, busy, done, table_valid, truth_table
  );

endinterface

// File: rtl/mux_sweep_sequencer_popcount.sv
// Combinational population count of a 32-bit vector (0..32).
module mux_seq_popcount
  import mux_seq_pkg::*;
(
  input  logic [NUM_VECTORS-1:0] vec_i,
  output logic [ERR_W-1:0]       count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      count_o = count_o + ERR_W'(vec_i[i]);
    end
  end

endmodule

// File: rtl/mux_sweep_sequencer.sv
// Walks all 32 {sel, dec_in} vectors, dwells DWELL cycles on each and
// records the mux output into a truth table. Optional golden compare: MUX_SEQ_COMPARE_EN.
module mux_sweep_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned DWELL = 2
) (
  input  logic     clk,
  input  logic     reset,
  mux_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_VECTORS - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_VECTORS-1:0] table_q, table_d;
  logic                   valid_q, valid_d;
  logic                   start_acc;
  logic                   finish;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    table_d   = table_q;
    valid_d   = valid_q;
    start_acc = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          start_acc = 1'b1;
          state_d   = RUN;
          idx_d     = '0;
          cnt_d     = CNT_RELOAD;
          table_d   = '0;
          valid_d   = 1'b0;
        end
      end
      RUN: begin
        // Abort wins over the end-of-dwell sample.
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          table_d[idx_q] = bus.mux_out;
          if (idx_q == IDX_LAST) begin
            finish  = 1'b1;
            state_d = DONE;
            idx_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            cnt_d = CNT_RELOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sel         = idx_q[IDX_W-1:DEC_W];
  assign bus.dec_in      = idx_q[DEC_W-1:0];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.table_valid = valid_q;
  assign bus.truth_table = table_q;

`ifdef MUX_SEQ_COMPARE_EN
  logic [ERR_W-1:0] pop;
  logic [ERR_W-1:0] err_q;
  logic             mismatch_q;

  // Compare the table as it will stand after the final sample is written.
  mux_seq_popcount u_popcount (
    .vec_i   (table_d ^ bus.expected),
    .count_o (pop)
  );

  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      err_q      <= '0;
      mismatch_q <= 1'b0;
    end else if (finish) begin
      err_q      <= pop;
      mismatch_q <= (pop != '0);
    end
  end

  assign bus.err_count = err_q;
  assign bus.mismatch  = mismatch_q;
`else
  logic unused_flags;
  assign unused_flags = start_acc ^ finish;
`endif

endmodule

// File: tb/tb_mux_sweep_sequencer.sv
// Directed bench: DWELL=2 sequencer on the lab function network and a
// DWELL=1 sequencer with its mux output tied high.
module tb_mux_sweep_sequencer;
  import mux_seq_pkg::*;

  localparam logic [31:0] GOLDEN = 32'h03D1C1E9;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_seq_if bus_a ();
  mux_seq_if bus_b ();

  mux_sweep_sequencer #(.DWELL(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  mux_sweep_sequencer #(.DWELL(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Lab network: 8:1 mux whose inputs are functions of the decoder input.
  function automatic logic lab_mux(input logic [2:0] s, input logic [1:0] d);
    case (s)
      3'd0:    return ~(d[1] ^ d[0]);
      3'd1:    return d != 2'd0;
      3'd2:    return d == 2'd0;
      3'd3:    return d[1];
      3'd4:    return d == 2'd0;
      3'd5:    return d != 2'd1;
      3'd6:    return ~d[1];
      default: return 1'b0;
    endcase
  endfunction

  always_comb bus_a.mux_out = lab_mux(bus_a.sel, bus_a.dec_in);
  assign bus_b.mux_out = 1'b1;
`ifdef MUX_SEQ_COMPARE_EN
  assign bus_b.expected = '1;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut_a and wait for done; leaves the bench in the done cycle.
  task automatic sweep_a(input string tag, input logic hold_start);
    int cyc;
    bus_a.start = 1'b1;
    tick();
    if (!hold_start) bus_a.start = 1'b0;
    cyc = 1;
    while (bus_a.done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_done_cycle"}, cyc, 65);
  endtask

  initial begin
    logic saw_done;
    int   cyc;

    reset       = 1'b1;
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    bus_b.start = 1'b0;
    bus_b.abort = 1'b0;
`ifdef MUX_SEQ_COMPARE_EN
    bus_a.expected = GOLDEN;
`endif
    repeat (3) tick();

    check("rst_busy", bus_a.busy, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_valid", bus_a.table_valid, 0);
    check("rst_table", bus_a.truth_table, 0);
    check("rst_vec", {bus_a.sel, bus_a.dec_in}, 0);
    check("rst_b_busy", bus_b.busy, 0);
    reset = 1'b0;
    tick();
    check("idle_busy", bus_a.busy, 0);

    // Full sweep on the lab network.
    sweep_a("sweep1", 1'b0);
    check("sweep1_table", bus_a.truth_table, GOLDEN);
    check("sweep1_valid", bus_a.table_valid, 1);
    check("sweep1_busy_in_done", bus_a.busy, 1);
`ifdef MUX_SEQ_COMPARE_EN
    check("cmp_match_mismatch", bus_a.mismatch, 0);
    check("cmp_match_err", bus_a.err_count, 0);
`endif
    tick();
    check("after_done_pulse", bus_a.done, 0);
    check("after_done_busy", bus_a.busy, 0);
    check("after_done_valid", bus_a.table_valid, 1);
    check("after_done_table", bus_a.truth_table, GOLDEN);

`ifdef MUX_SEQ_COMPARE_EN
    bus_a.expected = GOLDEN ^ 32'h1;
    sweep_a("cmp1", 1'b0);
    check("cmp1_mismatch", bus_a.mismatch, 1);
    check("cmp1_err", bus_a.err_count, 1);
    tick();
    bus_a.expected = ~GOLDEN;
    sweep_a("cmp32", 1'b0);
    check("cmp32_mismatch", bus_a.mismatch, 1);
    check("cmp32_err", bus_a.err_count, 32);
    tick();
    bus_a.expected = GOLDEN;
`endif

    // DWELL=1: one vector per cycle, all ones recorded.
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("b_vec", {bus_b.sel, bus_b.dec_in}, i);
      tick();
    end
    check("b_done", bus_b.done, 1);
    check("b_table", bus_b.truth_table, 32'hFFFF_FFFF);
    tick();
    check("b_idle", bus_b.busy, 0);

    // Abort during the 10th RUN cycle.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    repeat (9) tick();
    check("abort_pre_busy", bus_a.busy, 1);
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("abort_busy", bus_a.busy, 0);
    check("abort_done", bus_a.done, 0);
    check("abort_vec", {bus_a.sel, bus_a.dec_in}, 0);
    check("abort_valid", bus_a.table_valid, 0);
    check("abort_partial", bus_a.truth_table, 32'h0000_0009);
    saw_done = 1'b0;
    repeat (4) begin
      if (bus_a.done === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", saw_done, 0);
    sweep_a("after_abort", 1'b0);
    check("after_abort_table", bus_a.truth_table, GOLDEN);
    tick();

    // start held high: one IDLE cycle between back-to-back sweeps.
    sweep_a("held", 1'b1);
    tick();
    check("held_gap_busy", bus_a.busy, 0);
    check("held_gap_valid", bus_a.table_valid, 1);
    tick();
    check("held_second_busy", bus_a.busy, 1);
    check("held_second_valid", bus_a.table_valid, 0);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b1;
    tick();
    bus_a.abort = 1'b0;
    check("held_abort_busy", bus_a.busy, 0);

    // start and abort together in IDLE are ignored.
    bus_a.start = 1'b1;
    bus_a.abort = 1'b1;
    tick();
    check("pair_busy1", bus_a.busy, 0);
    tick();
    check("pair_busy2", bus_a.busy, 0);
    bus_a.start = 1'b0;
    bus_a.abort = 1'b0;
    tick();

    // Reset mid-RUN at idx=17, with start held during reset.
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    cyc = 0;
    while ({bus_a.sel, bus_a.dec_in} !== 5'd17 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("midrun_idx17", {bus_a.sel, bus_a.dec_in}, 17);
    reset       = 1'b1;
    bus_a.start = 1'b1;
    tick();
    check("midrst_busy", bus_a.busy, 0);
    check("midrst_done", bus_a.done, 0);
    check("midrst_vec", {bus_a.sel, bus_a.dec_in}, 0);
    check("midrst_valid", bus_a.table_valid, 0);
    check("midrst_table", bus_a.truth_table, 0);
    reset       = 1'b0;
    bus_a.start = 1'b0;
    tick();
    check("post_rst_busy", bus_a.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
